// File: rtl/banco_param_pkg.sv
// banco_param_pkg: shared defaults, read-latency codes and address-width helper for the register bank
package banco_param_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;
    localparam int RD_COMB    = 0;
    localparam int RD_REG     = 1;
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/banco_rd_port.sv
// banco_rd_port: one read port with range/zero-reg masking, write bypass and busy view
module banco_rd_port
    import banco_param_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = clog2_min1(DEPTH_DEF),
    parameter int READ_LAT = RD_COMB,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] mem [DEPTH],
    input  logic [DEPTH-1:0]  busy,
    input  logic              wr_ok,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rsv_ok,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DATA_W-1:0] rdata,
    output logic              rbusy
);
    logic              valid, byp, busy_c, rbusy_q;
    logic [DATA_W-1:0] data_c, rdata_q;
    assign valid  = (32'(raddr) < DEPTH) && !(ZERO_REG != 0 && raddr == '0);
    assign byp    = (BYPASS != 0) && wr_ok && waddr == raddr;
    assign data_c = !valid ? '0 : byp ? wdata : mem[raddr];
    // a retiring write hides the busy bit unless a new producer reserves it on the same edge
    assign busy_c = valid && busy[raddr] && !(byp && !(rsv_ok && rsv_addr == raddr));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            rbusy_q <= 1'b0;
        end else begin
            rdata_q <= data_c;
            rbusy_q <= busy_c;
        end
    end
    assign rdata = (READ_LAT == RD_REG) ? rdata_q : data_c;
    assign rbusy = (READ_LAT == RD_REG) ? rbusy_q : busy_c;
endmodule

// File: rtl/banco_param.sv
// banco_param: multi-port register bank with write bypass, selectable read latency and busy scoreboard
module banco_param
    import banco_param_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int DEPTH    = DEPTH_DEF,
    parameter  int NUM_RD   = 2,
    parameter  int READ_LAT = RD_COMB,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int ADDR_W   = clog2_min1(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     busy_any
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy, busy_nxt;
    logic              wr_ok, rsv_ok;
    // rst_n gating keeps a write caught by reset from leaking through the bypass path
    assign wr_ok  = rst_n && we && (32'(waddr) < DEPTH) && !(ZERO_REG != 0 && waddr == '0);
    assign rsv_ok = rst_n && rsv_en && (32'(rsv_addr) < DEPTH) && !(ZERO_REG != 0 && rsv_addr == '0);
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) busy_nxt[waddr] = 1'b0;
        if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < DEPTH; n++) mem[n] <= '0;
            busy <= '0;
        end else begin
            if (wr_ok) mem[waddr] <= wdata;
            busy <= busy_nxt;
        end
    end
    assign busy_any = |busy;
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        banco_rd_port #(
            .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
            .READ_LAT(READ_LAT), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_rd (
            .clk(clk), .rst_n(rst_n),
            .raddr(raddr[i*ADDR_W +: ADDR_W]),
            .mem(mem), .busy(busy),
            .wr_ok(wr_ok), .waddr(waddr), .wdata(wdata),
            .rsv_ok(rsv_ok), .rsv_addr(rsv_addr),
            .rdata(rdata[i*DATA_W +: DATA_W]),
            .rbusy(rbusy[i])
        );
    end
endmodule

// File: doc/banco_param.md
Name: banco_param

Overview:
- Parametrised, clocked successor to the single-write register bank. Provides NUM_RD read ports, one synchronous write port and an optional hardwired-zero register 0.
- Offers write-to-read bypass and a selectable read latency.
- Keeps a per-register busy scoreboard so the datapath can detect pending producers.
- Sits between decode (read addresses, reservations) and write-back (write port).

Parameters:
- DATA_W, 32, width of each register.
- DEPTH, 32, number of registers; any value >= 2.
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden).
- NUM_RD, 2, number of read ports; range 1..4.
- READ_LAT, 0, read latency: 0 = combinational, 1 = registered.
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes and reservations.
- BYPASS, 1, 1 = a same-cycle write is visible on reads of that address.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write enable (replaces RegEn)
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- raddr  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  packed read data, same packing
- rbusy  out  NUM_RD  busy flag of the addressed register, per read port
- rsv_en  in  1  reserve request: sets the busy bit of rsv_addr
- rsv_addr  in  ADDR_W  address to reserve
- busy_any  out  1  OR of all busy bits

Behaviour:
- Reset (rst_n low, asynchronous):
  - all DEPTH entries = 0; all busy bits = 0.
  - READ_LAT=1: the rdata and rbusy registers = 0.
  - busy_any = 0.
  - Reset asserted mid-write discards that write. First write is accepted on the first rising edge with rst_n high.
- Write:
  - Storage updates only on a rising clk edge with we=1.
  - Writes are ignored when waddr >= DEPTH, or when ZERO_REG=1 and waddr=0.
  - No combinational or latch write path exists.
- Read, READ_LAT=0:
  - rdata[i] = mem[raddr[i]] combinationally.
  - BYPASS=1, we=1, waddr==raddr[i] and the write is legal: rdata[i] = wdata.
- Read, READ_LAT=1:
  - rdata[i] is registered at the edge using the same selection, so it returns the value including that edge's write.
  - Latency is 1 cycle. rbusy is registered alongside rdata.
- Out-of-range raddr (>= DEPTH): rdata = 0, rbusy = 0.
- ZERO_REG=1: raddr=0 always gives rdata = 0 and rbusy = 0, with no bypass.
- Scoreboard:
  - At an edge, rsv_en=1 sets busy[rsv_addr]; a legal write clears busy[waddr].
  - Reservation and write to the same address in the same edge: the reservation wins and busy stays 1 (a new producer has been issued).
  - Reserving an already-busy register: stays 1, no error.
  - Reservations with out-of-range rsv_addr, or to reg 0 with ZERO_REG=1, are ignored.
- rbusy[i], combinational view (READ_LAT=0):
  - Equals busy[raddr[i]], except it is 0 when BYPASS=1 and a legal write to raddr[i] is in progress this cycle without a same-address rsv_en.
  - A same-cycle rsv_en does not affect rbusy until the next cycle.
- busy_any reflects the registered busy vector only (no bypass).
- Multiple read ports may use the same address; each returns identical data and busy.

Decomposition:
- Shared package holds:
  - the defaults DATA_W_DEF=32 and DEPTH_DEF=32;
  - a function clog2_min1, so that ADDR_W is at least 1;
  - the read-latency constants RD_COMB=0 and RD_REG=1.
- One sub-module, banco_rd_port: a single read mux plus bypass/busy logic, generated NUM_RD times. Storage and scoreboard stay in the top.

Test Plan:
- Reset with preloaded garbage, then release rst_n -> every raddr reads 0x00000000, rbusy=0, busy_any=0.
- Write 0xDEADBEEF to reg 5, READ_LAT=0, BYPASS=1, raddr0=5 in the same cycle -> rdata0=0xDEADBEEF before the edge. BYPASS=0 -> old value 0 until after the edge.
- ZERO_REG=1: write 0x12345678 to reg 0, rsv reg 0 -> rdata=0 and rbusy=0 on all ports; busy_any stays 0.
- rsv reg 7 -> next cycle rbusy=1, busy_any=1. Write 0xA5 to reg 7 -> rbusy=0 in the write cycle (bypass), busy clear after the edge. Reserve and write reg 9 on the same edge -> busy[9]=1 afterwards.
- READ_LAT=1, NUM_RD=4, all ports raddr=3 while writing 0x55 to reg 3 -> all four rdata=0x55 exactly one cycle later. DEPTH=20 with raddr=25 -> rdata=0.
- Assert rst_n low asynchronously mid-cycle while we=1 -> outputs go 0 immediately, without waiting for clk, and the written register remains 0 after release.
